// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Covers the jump-location codes, the reset PC, the fetch FSM states and the branch-target arithmetic.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Controller absJumpLoc encodings
    localparam logic absJumpImmediate = 1'b0;
    localparam logic absJumpRegister  = 1'b1;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    // Word-scaled signed offset added to the delay-slot address; wraps at 32 bits.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic signed [31:0] offset);
        logic signed [31:0] scaled;
        scaled = offset <<< 2;
        return pc_plus4 + scaled;
    endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC select for fetch.
// The choices are sequential, branch, jump-immediate and jump-register; a misaligned register target is also flagged.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic        [31:0] pc_f,
    input  logic        [31:0] pc_d,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic               jump_loc,
    input  logic signed [31:0] immediate,
    input  logic        [31:0] reg_target,
    output logic        [31:0] npc,
    output logic               misaligned
);

    logic [31:0] pc_d_plus4;

    always_comb begin
        pc_d_plus4 = pc_d + 32'd4;
        npc        = pc_f + 32'd4;
        misaligned = 1'b0;
        // Jump takes priority over a simultaneously taken branch
        if (jump) begin
            if (jump_loc == absJumpRegister) begin
                npc        = reg_target;
                misaligned = (reg_target[1:0] != 2'b00);
            end else begin
                npc = {pc_d_plus4[31:28], immediate[25:0], 2'b00};
            end
        end else if (branch_taken) begin
            npc = branch_target(pc_d_plus4, immediate);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID register for the five-stage MIPS core.
// Redirects from decode take effect after one delay slot. A syscall or a misaligned jr stops fetch until reset.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_loc,
    input  logic [31:0] immediate,
    input  logic [31:0] reg_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        bubble_d,
    output logic        halted,
    output logic        addr_error,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_f;
    logic [31:0]  npc;
    logic         misaligned;
    logic         advance;

    npc_calc u_npc (
        .pc_f         (pc_f),
        .pc_d         (pc_d),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_loc     (jump_loc),
        .immediate    (immediate),
        .reg_target   (reg_target),
        .npc          (npc),
        .misaligned   (misaligned)
    );

    assign advance   = (state == FETCH_RUN) && !stall;
    assign imem_addr = pc_f;

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH_RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (advance && (halt_req || misaligned)) state_next = FETCH_HALT;
    end

    always_comb begin
        halted = (state == FETCH_HALT);
    end

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f        <= RESET_PC;
            instr_d     <= 32'd0;
            pc_d        <= 32'd0;
            pc8_d       <= 32'd8;
            bubble_d    <= 1'b1;
            addr_error  <= 1'b0;
            fetch_count <= 32'd0;
        end else if (advance) begin
            if (halt_req || misaligned) begin
                // Syscall has no delay slot; a bad jr target squashes its slot too
                instr_d  <= 32'd0;
                bubble_d <= 1'b1;
                if (misaligned) addr_error <= 1'b1;
            end else begin
                pc_f        <= npc;
                instr_d     <= imem_rdata;
                pc_d        <= pc_f;
                pc8_d       <= pc_f + 32'd8;
                bubble_d    <= 1'b0;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit.
// The instruction memory returns its own address as the instruction word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jump_loc = 1'b0;
    logic [31:0] immediate = 32'd0;
    logic [31:0] reg_target = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        bubble_d;
    logic        halted;
    logic        addr_error;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_loc     (jump_loc),
        .immediate    (immediate),
        .reg_target   (reg_target),
        .halt_req     (halt_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc8_d        (pc8_d),
        .bubble_d     (bubble_d),
        .halted       (halted),
        .addr_error   (addr_error),
        .fetch_count  (fetch_count)
    );

    assign imem_rdata = imem_addr;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_loc = 1'b0;
        immediate = 32'd0; reg_target = 32'd0; halt_req = 1'b0;
    endtask

    task automatic do_reset();
        clear_ctl();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_addr", imem_addr, 32'h3000);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_pc8", pc8_d, 32'h8);
        chk("rst_bubble", {31'd0, bubble_d}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_aerr", {31'd0, addr_error}, 32'd0);
        chk("rst_fcnt", fetch_count, 32'd0);

        // Sequential fetch
        tick();
        chk("seq1_instr", instr_d, 32'h3000);
        chk("seq1_bubble", {31'd0, bubble_d}, 32'd0);
        tick();
        chk("seq2_instr", instr_d, 32'h3004);
        tick();
        chk("seq3_instr", instr_d, 32'h3008);
        chk("seq3_pc8", pc8_d, 32'h3010);
        chk("seq3_fcnt", fetch_count, 32'd3);

        // beq at 0x3004, immediate 3 -> 0x3008 + 12 = 0x3014
        do_reset();
        tick(); tick();
        chk("beq_pc_d", pc_d, 32'h3004);
        branch_taken = 1'b1; immediate = 32'd3;
        tick();
        clear_ctl();
        chk("beq_slot", instr_d, 32'h3008);
        chk("beq_addr", imem_addr, 32'h3014);
        tick();
        chk("beq_target", instr_d, 32'h3014);
        // Backward branch at 0x3014, immediate -2 -> 0x3018 - 8 = 0x3010
        branch_taken = 1'b1; immediate = 32'hFFFF_FFFE;
        tick();
        clear_ctl();
        chk("bneg_slot", instr_d, 32'h3018);
        tick();
        chk("bneg_target", instr_d, 32'h3010);

        // jal at 0x3004 with branch_taken also high: jump wins
        do_reset();
        tick(); tick();
        chk("jal_pc8", pc8_d, 32'h300C);
        jump = 1'b1; jump_loc = 1'b0; branch_taken = 1'b1; immediate = 32'h0000_0C10;
        tick();
        clear_ctl();
        chk("jal_slot", instr_d, 32'h3008);
        chk("jal_addr", imem_addr, 32'h3040);
        tick();
        chk("jal_pc_d", pc_d, 32'h3040);

        // Stall with pending branch
        do_reset();
        tick(); tick();
        stall = 1'b1; branch_taken = 1'b1; immediate = 32'd3;
        tick(); tick(); tick();
        chk("stall_addr", imem_addr, 32'h3008);
        chk("stall_instr", instr_d, 32'h3004);
        chk("stall_fcnt", fetch_count, 32'd2);
        stall = 1'b0;
        tick();
        branch_taken = 1'b0; immediate = 32'd0;
        chk("unstall_slot", instr_d, 32'h3008);
        chk("unstall_addr", imem_addr, 32'h3014);
        tick();
        chk("unstall_target", instr_d, 32'h3014);
        chk("unstall_fcnt", fetch_count, 32'd4);

        // syscall at 0x3010
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("sys_pc_d", pc_d, 32'h3010);
        chk("sys_pre_halted", {31'd0, halted}, 32'd0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("sys_bubble", {31'd0, bubble_d}, 32'd1);
        chk("sys_instr", instr_d, 32'h0);
        chk("sys_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("halt_addr", imem_addr, 32'h3014);
        chk("halt_fcnt", fetch_count, 32'd5);
        chk("halt_still", {31'd0, halted}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("halt_rst_addr", imem_addr, 32'h3000);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);

        // Aligned jr then misaligned jr
        do_reset();
        tick();
        jump = 1'b1; jump_loc = 1'b1; reg_target = 32'h4000;
        tick();
        clear_ctl();
        chk("jr_slot", instr_d, 32'h3004);
        chk("jr_addr", imem_addr, 32'h4000);
        tick();
        chk("jr_target", instr_d, 32'h4000);
        jump = 1'b1; jump_loc = 1'b1; reg_target = 32'h3002;
        tick();
        clear_ctl();
        chk("jrbad_aerr", {31'd0, addr_error}, 32'd1);
        chk("jrbad_halted", {31'd0, halted}, 32'd1);
        chk("jrbad_bubble", {31'd0, bubble_d}, 32'd1);
        chk("jrbad_addr", imem_addr, 32'h4004);
        chk("jrbad_fcnt", fetch_count, 32'd3);
        tick(); tick();
        chk("jrbad_sticky", {31'd0, addr_error}, 32'd1);
        do_reset();
        chk("jrbad_rst", {31'd0, addr_error}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
